// File: rtl/sseg_pkg.sv
// Shared constants, FSM encoding and segment decode for the seven-segment driver.
// Segment bytes are active low: bit7 = dp (held off), bits6:0 = g..a.
package sseg_pkg;

  localparam logic [7:0] SSEG_0     = 8'hC0;
  localparam logic [7:0] SSEG_1     = 8'hF9;
  localparam logic [7:0] SSEG_2     = 8'hA4;
  localparam logic [7:0] SSEG_3     = 8'hB0;
  localparam logic [7:0] SSEG_4     = 8'h99;
  localparam logic [7:0] SSEG_5     = 8'h92;
  localparam logic [7:0] SSEG_6     = 8'h82;
  localparam logic [7:0] SSEG_7     = 8'hF8;
  localparam logic [7:0] SSEG_8     = 8'h80;
  localparam logic [7:0] SSEG_9     = 8'h90;
  localparam logic [7:0] SSEG_A     = 8'h88;
  localparam logic [7:0] SSEG_B     = 8'h83;
  localparam logic [7:0] SSEG_C     = 8'hC6;
  localparam logic [7:0] SSEG_D     = 8'hA1;
  localparam logic [7:0] SSEG_E     = 8'h86;
  localparam logic [7:0] SSEG_F     = 8'h8E;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StCommit = 2'd2
  } state_e;

  // Full hex decode; BCD nibbles never exceed 9 so the decimal path only uses 0-9.
  function automatic logic [7:0] encode_to_sseg(input logic [3:0] nibble);
    logic [7:0] seg;
    unique case (nibble)
      4'h0: seg = SSEG_0;
      4'h1: seg = SSEG_1;
      4'h2: seg = SSEG_2;
      4'h3: seg = SSEG_3;
      4'h4: seg = SSEG_4;
      4'h5: seg = SSEG_5;
      4'h6: seg = SSEG_6;
      4'h7: seg = SSEG_7;
      4'h8: seg = SSEG_8;
      4'h9: seg = SSEG_9;
      4'hA: seg = SSEG_A;
      4'hB: seg = SSEG_B;
      4'hC: seg = SSEG_C;
      4'hD: seg = SSEG_D;
      4'hE: seg = SSEG_E;
      4'hF: seg = SSEG_F;
    endcase
    return seg;
  endfunction

  // Elaboration-time 10**n, wide enough for nine digits.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD (shift-add-3), one bit per clock.
// start loads a new value; done is high during the clock whose edge performs the
// final iteration, so bcd is complete on the following cycle.
// Only NUM_DIGITS nibbles are kept: carries only move upward, so truncating the
// top never corrupts the lower digits.
module bin_to_bcd_seq
  import sseg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int unsigned BcdW = 4 * NUM_DIGITS;
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BcdW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  active_q, active_d;

  // One iteration: add 3 to every nibble >= 5, then shift in the next value bit.
  always_comb begin
    bcd_adj  = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      shreg_d  = value;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      shreg_d = shreg_q << 1;
      bcd_d   = {bcd_adj[BcdW-2:0], shreg_q[DATA_WIDTH-1]};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LastCnt) active_d = 1'b0;
    end
  end

  // Datapath and iteration counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shreg_q  <= shreg_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done = active_q && (cnt_q == LastCnt);
  assign bcd  = bcd_q;

endmodule

// File: rtl/sseg_mux_display.sv
// Multiplexed seven-segment display driver: load/busy conversion handshake,
// overflow detection (shown as dashes) and a prescaled digit scanner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most
// significant non-zero digit (digit 0 and dashes are never blanked).
module sseg_mux_display
  import sseg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  load,
  input  logic                  hex_mode,
  output logic                  busy,
  output logic                  overflow,
  output logic [7:0]            sseg_indicator,
  output logic [NUM_DIGITS-1:0] digits
);

  localparam int unsigned BufW = 4 * NUM_DIGITS;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = $clog2(REFRESH_DIV);
  localparam longint unsigned DecLimit = pow10(NUM_DIGITS);

  state_e state_q, state_d;
  logic   accept, start, commit;
  logic   dec_ovf, hex_ovf, ovf_now;
  logic   bcd_done;
  logic [BufW-1:0] bcd;

  logic [BufW+DATA_WIDTH-1:0] in_ext;
  logic            mode_q, ovf_pend_q;
  logic [BufW-1:0] hex_q;
  logic [BufW-1:0] disp_q;
  logic            overflow_q;

  logic [PreW-1:0] presc_q;
  logic [IdxW-1:0] idx_q;
  logic            tick, slot_start_q;
  logic [NUM_DIGITS-1:0] blank;
  logic [7:0]      seg_next;
  logic [7:0]      sseg_q;
  logic [NUM_DIGITS-1:0] digits_q;

  // Lower BufW bits are the hex nibbles; anything above them cannot be shown in hex.
  assign in_ext  = {{BufW{1'b0}}, value};
  assign hex_ovf = |in_ext[BufW +: DATA_WIDTH];
  assign dec_ovf = 64'(value) >= DecLimit;
  assign ovf_now = hex_mode ? hex_ovf : dec_ovf;
  assign start   = accept && !ovf_now && !hex_mode;

  bin_to_bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin_to_bcd (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .value (value),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state: hex and overflow skip the BCD shifter entirely.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (load) state_d = (ovf_now || hex_mode) ? StCommit : StShift;
      StShift:  if (bcd_done) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: loads are only taken in idle, so a load while busy is dropped.
  always_comb begin
    accept = 1'b0;
    commit = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      StIdle:   accept = load;
      StShift:  busy   = 1'b1;
      StCommit: begin
        busy   = 1'b1;
        commit = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture mode, overflow verdict and hex nibbles at the accepted load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      hex_q      <= '0;
    end else if (accept) begin
      mode_q     <= hex_mode;
      ovf_pend_q <= ovf_now;
      hex_q      <= in_ext[BufW-1:0];
    end
  end

  // Display buffer and overflow flag change only on commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else if (commit) begin
      overflow_q <= ovf_pend_q;
      if (ovf_pend_q)  disp_q <= '0;
      else if (mode_q) disp_q <= hex_q;
      else             disp_q <= bcd;
    end
  end

  assign tick = presc_q == PreW'(REFRESH_DIV - 1);

  // Prescaler and scan index; slot_start_q marks the cycle after an index change
  // (and the first cycle out of reset, so digit 0 is shown immediately).
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      slot_start_q <= 1'b1;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      slot_start_q <= tick;
      if (tick) idx_q <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;
`endif

  // Segment pattern for the digit selected by the scan index.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    seen_nz = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      blank[i] = ~seen_nz;
    end
`endif
    if (overflow_q)        seg_next = SSEG_DASH;
    else if (blank[idx_q]) seg_next = SSEG_BLANK;
    else                   seg_next = encode_to_sseg(disp_q[4*idx_q +: 4]);
  end

  // Segments and anode latch together at slot start, so a mid-slot buffer
  // update never shows within the current slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sseg_q   <= SSEG_BLANK;
      digits_q <= '1;
    end else if (slot_start_q) begin
      sseg_q   <= seg_next;
      digits_q <= ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  assign sseg_indicator = sseg_q;
  assign digits         = digits_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_sseg_mux_display.sv
// Directed bench for sseg_mux_display: vector table plus hand sequences for
// busy-ignore, held load, and reset during conversion.
module tb_sseg_mux_display;

  localparam int DW = 16;
  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] value;
  logic          load;
  logic          hex_mode;
  logic          busy;
  logic          overflow;
  logic [7:0]    sseg_indicator;
  logic [ND-1:0] digits;

  int checks;
  int passed;

  sseg_mux_display #(
    .DATA_WIDTH  (DW),
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .value          (value),
    .load           (load),
    .hex_mode       (hex_mode),
    .busy           (busy),
    .overflow       (overflow),
    .sseg_indicator (sseg_indicator),
    .digits         (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     val;
    logic            hex;
    int              lat;
    logic            ovf;
    logic [3:0][7:0] seg;  // seg[0] = digit 0
    int              lz;   // top digits blanked when leading-zero blanking is built in
  } vec_t;

  vec_t vecs[9];

  // Segments must never change while the same anode stays selected.
  logic [ND-1:0] prev_digits;
  logic [7:0]    prev_seg;
  int            glitches;
  logic          mon_en;

  always @(negedge clk) begin
    if (mon_en && digits == prev_digits && sseg_indicator != prev_seg) glitches <= glitches + 1;
    prev_digits <= digits;
    prev_seg    <= sseg_indicator;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0][7:0] apply_lz(input logic [3:0][7:0] s, input int lz);
    logic [3:0][7:0] r;
    r = s;
`ifdef LEADING_ZERO_BLANK_EN
    for (int d = ND - lz; d < ND; d++) r[d] = 8'hFF;
`endif
    return r;
  endfunction

  // Pulse load for one cycle and count cycles with busy high (bounded).
  task automatic do_load(input logic [15:0] v, input logic h, output int lat);
    @(negedge clk);
    value    = v;
    hex_mode = h;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 0;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      @(negedge clk);
    end
  endtask

  // Let the display settle, then record what each anode shows over two scans.
  task automatic scan(output logic [3:0][7:0] segs, output logic ok);
    logic [3:0] seen;
    seen = '0;
    ok   = 1'b1;
    segs = '1;
    repeat (ND * RD + RD + 2) @(negedge clk);
    for (int n = 0; n < 2 * ND * RD; n++) begin
      @(negedge clk);
      if (!$onehot(~digits)) ok = 1'b0;
      else begin
        for (int d = 0; d < ND; d++) begin
          if (!digits[d]) begin
            segs[d] = sseg_indicator;
            seen[d] = 1'b1;
          end
        end
      end
    end
    if (seen != 4'hF) ok = 1'b0;
  endtask

  task automatic check_scan(input string name, input logic [3:0][7:0] exp_raw, input int lz);
    logic [3:0][7:0] got;
    logic [3:0][7:0] expv;
    logic            ok;
    expv = apply_lz(exp_raw, lz);
    scan(got, ok);
    check({name, " one-hot scan"}, ok, 1);
    for (int d = 0; d < ND; d++) check($sformatf("%s digit%0d", name, d), got[d], expv[d]);
  endtask

  initial begin
    int         lat;
    logic [3:0] bpat;

    checks   = 0;
    passed   = 0;
    glitches = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    load     = 1'b0;
    hex_mode = 1'b0;
    value    = '0;

    vecs[0] = '{val: 16'd359,   hex: 1'b0, lat: 17, ovf: 1'b0,
                seg: {8'hC0, 8'hB0, 8'h92, 8'h90}, lz: 1};
    vecs[1] = '{val: 16'hBEEF,  hex: 1'b1, lat: 1,  ovf: 1'b0,
                seg: {8'h83, 8'h86, 8'h86, 8'h8E}, lz: 0};
    vecs[2] = '{val: 16'd12345, hex: 1'b0, lat: 1,  ovf: 1'b1,
                seg: {8'hBF, 8'hBF, 8'hBF, 8'hBF}, lz: 0};
    vecs[3] = '{val: 16'd42,    hex: 1'b0, lat: 17, ovf: 1'b0,
                seg: {8'hC0, 8'hC0, 8'h99, 8'hA4}, lz: 2};
    vecs[4] = '{val: 16'd9999,  hex: 1'b0, lat: 17, ovf: 1'b0,
                seg: {8'h90, 8'h90, 8'h90, 8'h90}, lz: 0};
    vecs[5] = '{val: 16'd10000, hex: 1'b0, lat: 1,  ovf: 1'b1,
                seg: {8'hBF, 8'hBF, 8'hBF, 8'hBF}, lz: 0};
    vecs[6] = '{val: 16'd7,     hex: 1'b0, lat: 17, ovf: 1'b0,
                seg: {8'hC0, 8'hC0, 8'hC0, 8'hF8}, lz: 3};
    vecs[7] = '{val: 16'd0,     hex: 1'b0, lat: 17, ovf: 1'b0,
                seg: {8'hC0, 8'hC0, 8'hC0, 8'hC0}, lz: 3};
    vecs[8] = '{val: 16'h0A05,  hex: 1'b1, lat: 1,  ovf: 1'b0,
                seg: {8'hC0, 8'h88, 8'hC0, 8'h92}, lz: 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset sseg", sseg_indicator, 8'hFF);
    check("reset digits", digits, 4'hF);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    reset = 1'b1;
    @(negedge clk);
    check("first slot digits", digits, 4'b1110);
    check("first slot sseg", sseg_indicator, 8'hC0);
    mon_en = 1'b1;

    // Table-driven loads
    for (int k = 0; k < 9; k++) begin
      do_load(vecs[k].val, vecs[k].hex, lat);
      check($sformatf("vec%0d busy cycles", k), lat, vecs[k].lat);
      check($sformatf("vec%0d overflow", k), overflow, vecs[k].ovf);
      check($sformatf("vec%0d busy idle", k), busy, 0);
      check_scan($sformatf("vec%0d", k), vecs[k].seg, vecs[k].lz);
    end

    // Load of 999 during a 359 conversion is dropped
    @(negedge clk);
    value    = 16'd359;
    hex_mode = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    lat  = 0;
    while (busy === 1'b1 && lat < 100) begin
      lat++;
      if (lat == 4) begin
        value = 16'd999;
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("ignored load busy cycles", lat, 17);
    repeat (2) @(negedge clk);
    check("ignored load not queued", busy, 0);
    check_scan("ignored load", {8'hC0, 8'hB0, 8'h92, 8'h90}, 1);

    // Held load retriggers every idle cycle (hex: one busy cycle each)
    @(negedge clk);
    value    = 16'h1234;
    hex_mode = 1'b1;
    load     = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bpat[n] = busy;
    end
    load = 1'b0;
    check("held load busy pattern", bpat, 4'b0101);
    check_scan("held load", {8'hF9, 8'hA4, 8'hB0, 8'h99}, 0);

    // Reset during SHIFT aborts without committing; overflow from before clears
    do_load(16'd12345, 1'b0, lat);
    check("pre-reset overflow", overflow, 1);
    @(negedge clk);
    value    = 16'd9999;
    hex_mode = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-shift busy", busy, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mid-shift sseg", sseg_indicator, 8'hFF);
    check("reset mid-shift digits", digits, 4'hF);
    check("reset mid-shift busy", busy, 0);
    check("reset mid-shift overflow", overflow, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset digits", digits, 4'b1110);
    check("post-reset sseg", sseg_indicator, 8'hC0);
    repeat (20) @(negedge clk);
    check("post-reset busy", busy, 0);
    check("post-reset overflow", overflow, 0);
    check_scan("post-reset", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, 3);

    check("mid-slot segment changes", glitches, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
